// File: rtl/seq_controller.sv
// Fetch/execute sequencer for the 8-bit accumulator datapath.
// Optional retire counter: define SEQ_RETIRE_COUNT_EN to add o-port retire_cnt.
module seq_controller #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 15,
    parameter int OPC_W   = 7,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               flag_z,
    input  logic               flag_n,
    output logic [OPC_W-1:0]   ir_opcode,
    output logic [7:0]         ir_literal,
    output logic               exec_en,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               halted,
    output logic               err
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [15:0]        retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7'h40);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(7'h41);
    localparam logic [OPC_W-1:0] OP_JN  = OPC_W'(7'h42);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(7'h7F);
    localparam logic [7:0]       TMAX   = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [INSTR_W-1:0]  r_ir;
    logic [7:0]          r_timer;
    logic [OPC_W-1:0]    w_opc;
    logic [7:0]          w_lit;
    logic                w_is_jmp;
    logic                w_is_jz;
    logic                w_is_jn;
    logic                w_is_hlt;
    logic                w_ctrl;
    logic                w_take;
    logic                w_req;
    logic                w_exec;

    assign w_opc    = r_ir[OPC_W+7:8];
    assign w_lit    = r_ir[7:0];
    assign w_is_jmp = (w_opc == OP_JMP);
    assign w_is_jz  = (w_opc == OP_JZ);
    assign w_is_jn  = (w_opc == OP_JN);
    assign w_is_hlt = (w_opc == OP_HLT);
    assign w_ctrl   = w_is_jmp | w_is_jz | w_is_jn | w_is_hlt;
    assign w_take   = w_is_jmp
                    | (w_is_jz & flag_z)
                    | (w_is_jn & flag_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_req     = 1'b0;
        w_exec    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_valid) begin
                    w_next = S_EXEC;
                end else if (r_timer == TMAX) begin
                    w_next = S_ERROR;
                end
            end
            S_EXEC: begin
                w_exec = ~w_ctrl;
                w_next = w_is_hlt ? S_HALT : S_FETCH;
                // taken jumps load the literal; everything else steps
                if (w_take) begin
                    w_pc_next = ADDR_W'(w_lit);
                end else begin
                    w_pc_next = r_pc + ADDR_W'(1);
                end
            end
            S_HALT: begin
                if (start) w_next = S_FETCH;
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_timer <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (r_state == S_FETCH) begin
                if (imem_valid) begin
                    r_ir    <= imem_rdata;
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 8'd1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0] r_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire <= '0;
        end else if (r_state == S_EXEC) begin
            r_retire <= r_retire + 16'd1;
        end
    end

    assign retire_cnt = r_retire;
`endif

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign pc_out     = r_pc;
    assign exec_en    = w_exec;
    assign ir_opcode  = w_opc;
    assign ir_literal = w_lit;
    assign busy       = (r_state == S_FETCH) | (r_state == S_EXEC);
    assign halted     = (r_state == S_HALT);
    assign err        = (r_state == S_ERROR);

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller with an expected-result queue.
// Define SEQ_RETIRE_COUNT_EN to also track retire_cnt.
module tb_seq_controller;

    localparam int TO = 15;

    typedef struct {
        logic [6:0] opc;
        logic [7:0] lit;
        logic       ex;
        logic       hlt;
        logic [7:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [14:0] imem_rdata;
    logic        imem_valid;
    logic        flag_z;
    logic        flag_n;
    logic [6:0]  ir_opcode;
    logic [7:0]  ir_literal;
    logic        exec_en;
    logic [7:0]  pc_out;
    logic        busy;
    logic        halted;
    logic        err;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0] retire_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    exp_t sb[$];

    seq_controller #(
        .ADDR_W(8), .INSTR_W(15), .OPC_W(7), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .flag_z(flag_z), .flag_n(flag_n),
        .ir_opcode(ir_opcode), .ir_literal(ir_literal),
        .exec_en(exec_en), .pc_out(pc_out), .busy(busy),
        .halted(halted), .err(err)
`ifdef SEQ_RETIRE_COUNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ret();
`ifdef SEQ_RETIRE_COUNT_EN
        chk("retire_cnt", {16'h0, retire_cnt}, {16'h0, m_ret});
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic [7:0] lit,
                             input int dly, input logic fz, input logic fn);
        exp_t e;
        logic take;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_exec", exec_en, 0);
            chk("wait_err", err, 0);
        end
        imem_rdata = {opc, lit};
        imem_valid = 1'b1;
        flag_z     = fz;
        flag_n     = fn;
        take  = (opc == 7'h40) || (opc == 7'h41 && fz)
             || (opc == 7'h42 && fn);
        e.opc = opc;
        e.lit = lit;
        e.hlt = (opc == 7'h7F);
        e.ex  = !(opc == 7'h40 || opc == 7'h41 || opc == 7'h42 || e.hlt);
        e.pc  = take ? lit : m_pc + 8'd1;
        sb.push_back(e);
        step();
        // junk valid during EXEC must not reach the IR
        imem_rdata = ~{opc, lit};
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("exec_en", exec_en, e.ex);
            chk("ir_opcode", ir_opcode, e.opc);
            chk("ir_literal", ir_literal, e.lit);
            chk("exec_busy", busy, 1);
            chk("exec_req", imem_req, 0);
            step();
            imem_valid = 1'b0;
            m_pc  = e.pc;
            m_ret = m_ret + 16'd1;
            chk("pc_next", pc_out, m_pc);
            chk("exec_drop", exec_en, 0);
            chk("ir_hold", ir_literal, e.lit);
            chk("halted", halted, e.hlt);
            chk("busy_after", busy, !e.hlt);
            chk_ret();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        flag_z     = 1'b0;
        flag_n     = 1'b0;
        m_pc       = 8'h00;
        m_ret      = 16'h0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_exec", exec_en, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halt", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_opc", ir_opcode, 0);
        chk("rst_lit", ir_literal, 0);
        // start held during reset has no effect
        start = 1'b1;
        step();
        step();
        chk("rst_dom", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk_ret();

        pulse_start();
        run_instr(7'h01, 8'h05, 0, 1'b0, 1'b0);
        run_instr(7'h02, 8'h33, 3, 1'b0, 1'b0);
        run_instr(7'h3F, 8'hAA, 1, 1'b1, 1'b1);
        run_instr(7'h41, 8'h20, 0, 1'b1, 1'b0);
        run_instr(7'h40, 8'h03, 2, 1'b0, 1'b0);
        run_instr(7'h41, 8'h20, 0, 1'b0, 1'b1);
        run_instr(7'h42, 8'h0F, 0, 1'b0, 1'b1);
        run_instr(7'h42, 8'h50, 0, 1'b1, 1'b0);
        run_instr(7'h43, 8'h77, 0, 1'b1, 1'b1);
        run_instr(7'h40, 8'h10, 0, 1'b0, 1'b0);
        run_instr(7'h7F, 8'h00, 0, 1'b0, 1'b0);

        imem_valid = 1'b1;
        step();
        step();
        imem_valid = 1'b0;
        chk("halt_hold", halted, 1);
        chk("halt_req", imem_req, 0);
        chk("halt_pc", pc_out, 8'h11);
        chk("halt_ir", ir_opcode, 7'h7F);
        chk_ret();
        pulse_start();
        chk("resume_addr", imem_addr, 8'h11);
        chk("resume_halt", halted, 0);

        run_instr(7'h40, 8'hFF, 0, 1'b0, 1'b0);
        run_instr(7'h05, 8'h12, 1, 1'b0, 1'b0);
        chk("wrap_pc", pc_out, 8'h00);
        run_instr(7'h07, 8'h01, 0, 1'b0, 1'b0);

        for (int i = 1; i < TO; i++) begin
            step();
        end
        chk("to_pre_err", err, 0);
        chk("to_pre_req", imem_req, 1);
        step();
        chk("to_err", err, 1);
        chk("to_req", imem_req, 0);
        chk("to_busy", busy, 0);
        pulse_start();
        step();
        chk("err_sticky", err, 1);
        chk("err_pc", pc_out, m_pc);
        chk_ret();
        rst_n = 1'b0;
        #1;
        m_pc  = 8'h00;
        m_ret = 16'h0;
        chk("clr_err", err, 0);
        chk("clr_pc", pc_out, 0);
        chk_ret();
        step();
        rst_n = 1'b1;
        step();

        pulse_start();
        run_instr(7'h09, 8'h00, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_pc  = 8'h00;
        m_ret = 16'h0;
        chk("abort_f_req", imem_req, 0);
        chk("abort_f_pc", pc_out, 0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        run_instr(7'h0A, 8'h44, 0, 1'b0, 1'b0);
        imem_rdata = {7'h0B, 8'h55};
        imem_valid = 1'b1;
        step();
        imem_valid = 1'b0;
        chk("abort_e_pre", exec_en, 1);
        rst_n = 1'b0;
        #1;
        m_pc  = 8'h00;
        m_ret = 16'h0;
        chk("abort_e_exec", exec_en, 0);
        chk("abort_e_pc", pc_out, 0);
        chk("abort_e_ir", ir_literal, 0);
        chk_ret();
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
